// File: rtl/stall_sched.sv
// -----------------------------------------------------------------------------
// stall_sched
//
// Pipeline hold controller for a 5-stage MIPS-style core. It combines two
// sources of stall:
//   * a load-use hazard between the load in EX and a source operand in ID,
//     which holds PC/IF/ID for one cycle so a bubble enters EX;
//   * a multi-cycle divide, sequenced by an IDLE/BUSY/DONE FSM, which holds
//     PC/IF/ID/EX while the external iterative divider works.
// It also counts the cycles in which any stage is held.
//
// Ports
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous, active-high reset
//   id_re1      in   1   ID reads source operand 1
//   id_raddr1   in   5   ID source register 1
//   id_re2      in   1   ID reads source operand 2
//   id_raddr2   in   5   ID source register 2
//   ex_wreg     in   1   EX instruction writes a register
//   ex_waddr    in   5   EX destination register
//   ex_is_load  in   1   EX instruction is a load
//   div_start   in   1   EX holds a valid divide
//   flush       in   1   pipeline flush, aborts an in-flight divide
//   stall       out  6   hold per stage: {WB, MEM, EX, ID, IF, PC}
//   div_go      out  1   start pulse to the divider
//   div_done    out  1   divider result valid, write HI/LO
//   busy        out  1   FSM not in IDLE
//   stall_cnt   out  32  cycles with stall != 0 (wraps)
// -----------------------------------------------------------------------------
module stall_sched #(
   parameter int DIV_CYCLES = 32   // BUSY cycles per divide, 2..63
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_re1,
   input  logic [4:0]  id_raddr1,
   input  logic        id_re2,
   input  logic [4:0]  id_raddr2,
   input  logic        ex_wreg,
   input  logic [4:0]  ex_waddr,
   input  logic        ex_is_load,
   input  logic        div_start,
   input  logic        flush,
   output logic [5:0]  stall,
   output logic        div_go,
   output logic        div_done,
   output logic        busy,
   output logic [31:0] stall_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [5:0] HOLD_ID  = 6'b000111;  // PC, IF, ID
   localparam logic [5:0] HOLD_EX  = 6'b001111;  // PC, IF, ID, EX
   localparam logic [5:0] CNT_LOAD = 6'(DIV_CYCLES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] cnt;
   logic [5:0] cnt_nxt;
   logic [5:0] fsm_stall;
   logic       go_raw;
   logic       done_raw;
   logic       lu;

   // Load-use hazard: the load's data only reaches the forwarding path in
   // MEM, so a dependent instruction in ID must wait one cycle. $0 is
   // hard-wired to zero and never creates a dependency.
   always_comb begin
      lu = ex_is_load && ex_wreg && (ex_waddr != 5'd0) &&
           ((id_re1 && (id_raddr1 == ex_waddr)) ||
            (id_re2 && (id_raddr2 == ex_waddr)));
   end

   // Divide sequencer: next state, counter and FSM outputs.
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // leaves one unassigned, which would infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      fsm_stall = '0;
      go_raw    = 1'b0;
      done_raw  = 1'b0;

      unique case (state)
         IDLE: begin
            if (div_start && !flush) begin
               go_raw    = 1'b1;
               fsm_stall = HOLD_EX;
               cnt_nxt   = CNT_LOAD;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            // EX stays held in the cycle a flush arrives; the flush only
            // redirects the next state.
            fsm_stall = HOLD_EX;
            if (cnt == 6'd0) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 6'd1;
            end
         end
         DONE: begin
            done_raw  = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // A flush abandons whatever the divider is doing.
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         go_raw    = 1'b0;
         done_raw  = 1'b0;
      end
   end

   // Outputs are forced low while reset is held, independent of inputs.
   always_comb begin
      stall    = rst ? 6'd0 : ((lu ? HOLD_ID : 6'd0) | fsm_stall);
      div_go   = go_raw   && !rst;
      div_done = done_raw && !rst;
      busy     = (state != IDLE) && !rst;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         stall_cnt <= '0;
      end else begin
         // NOTE: state registers use non-blocking assignment so every
         // flop samples pre-edge values regardless of statement order.
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (stall != 6'd0) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_stall_sched.sv
// -----------------------------------------------------------------------------
// tb_stall_sched
//
// Drives stall_sched with directed scenarios followed by random traffic. A
// timeline model (cycles elapsed since the divide was launched) predicts
// every output each cycle; literal expectations pin the model on the
// documented scenarios.
// -----------------------------------------------------------------------------
module tb_stall_sched;

   localparam int N = 32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_re1 = 1'b0;
   logic [4:0]  id_raddr1 = '0;
   logic        id_re2 = 1'b0;
   logic [4:0]  id_raddr2 = '0;
   logic        ex_wreg = 1'b0;
   logic [4:0]  ex_waddr = '0;
   logic        ex_is_load = 1'b0;
   logic        div_start = 1'b0;
   logic        flush = 1'b0;
   logic [5:0]  stall;
   logic        div_go;
   logic        div_done;
   logic        busy;
   logic [31:0] stall_cnt;

   stall_sched #(.DIV_CYCLES(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_re1     (id_re1),
      .id_raddr1  (id_raddr1),
      .id_re2     (id_re2),
      .id_raddr2  (id_raddr2),
      .ex_wreg    (ex_wreg),
      .ex_waddr   (ex_waddr),
      .ex_is_load (ex_is_load),
      .div_start  (div_start),
      .flush      (flush),
      .stall      (stall),
      .div_go     (div_go),
      .div_done   (div_done),
      .busy       (busy),
      .stall_cnt  (stall_cnt)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: phase = cycles since div_go (-1 = no divide active).
   int          phase = -1;
   logic [31:0] m_cnt = '0;

   // Last sampled DUT outputs, for the literal checks.
   logic [5:0]  s_stall;
   logic        s_go;
   logic        s_done;
   logic        s_busy;
   logic [31:0] s_cnt;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock cycle: apply inputs after the falling edge, compare all
   // outputs against the model, then advance the model across the edge.
   task automatic step(input logic r, input logic ds, input logic fl,
                       input logic ld, input logic wr, input logic [4:0] wa,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
      logic [5:0] e_stall;
      logic       e_go;
      logic       e_done;
      logic       e_busy;
      logic       hz;
      logic       hold;
      @(negedge clk);
      rst = r; div_start = ds; flush = fl;
      ex_is_load = ld; ex_wreg = wr; ex_waddr = wa;
      id_re1 = re1; id_raddr1 = ra1; id_re2 = re2; id_raddr2 = ra2;
      #1;
      s_stall = stall; s_go = div_go; s_done = div_done;
      s_busy = busy; s_cnt = stall_cnt;

      e_stall = '0; e_go = 1'b0; e_done = 1'b0; e_busy = 1'b0;
      if (r) begin
         phase = -1;
         m_cnt = '0;
      end else begin
         hz = ld && wr && (wa != 5'd0) &&
              ((re1 && (ra1 == wa)) || (re2 && (ra2 == wa)));
         hold = 1'b0;
         if (phase < 0) begin
            if (ds && !fl) begin
               e_go = 1'b1;
               hold = 1'b1;
            end
         end else begin
            e_busy = 1'b1;
            hold   = (phase <= N);
            e_done = (phase == N + 1) && !fl;
         end
         e_stall = (hz ? 6'b000111 : 6'b000000) | (hold ? 6'b001111 : 6'b000000);
      end

      check("stall",     {26'd0, s_stall}, {26'd0, e_stall});
      check("div_go",    32'(s_go),        32'(e_go));
      check("div_done",  32'(s_done),      32'(e_done));
      check("busy",      32'(s_busy),      32'(e_busy));
      check("stall_cnt", s_cnt,            m_cnt);

      if (!r) begin
         if (e_stall != 6'd0) m_cnt = m_cnt + 32'd1;
         if (phase < 0)                       phase = e_go ? 1 : -1;
         else if (fl || (phase == N + 1))     phase = -1;
         else                                 phase = phase + 1;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
   endtask

   task automatic start_div();
      step(0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset held, with hazard and divide request present.
      step(1, 1, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);
      check("lit_rst_stall", {26'd0, s_stall}, 32'd0);
      check("lit_rst_go",    32'(s_go),        32'd0);
      check("lit_rst_busy",  32'(s_busy),      32'd0);
      check("lit_rst_cnt",   s_cnt,            32'd0);
      idle(2);

      // Load-use on register 5.
      step(0, 0, 0, 1, 1, 5'd5, 1, 5'd5, 0, 5'd0);
      check("lit_lu_stall", {26'd0, s_stall}, 32'h07);
      idle(1);
      check("lit_lu_cnt", s_cnt, 32'd1);

      // Same pattern on $0: no hazard.
      step(0, 0, 0, 1, 1, 5'd0, 1, 5'd0, 0, 5'd0);
      check("lit_r0_stall", {26'd0, s_stall}, 32'd0);
      idle(1);
      check("lit_r0_cnt", s_cnt, 32'd1);

      // Full divide launched at cycle 10 after reset.
      step(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      idle(10);
      start_div();
      check("lit_div_go",    32'(s_go),        32'd1);
      check("lit_div_stall", {26'd0, s_stall}, 32'h0f);
      for (int c = 11; c <= 42; c++) begin
         idle(1);
         check("lit_div_hold", {26'd0, s_stall}, 32'h0f);
      end
      idle(1);
      check("lit_div_done",   32'(s_done),      32'd1);
      check("lit_done_stall", {26'd0, s_stall}, 32'd0);
      idle(1);
      check("lit_div_idle", 32'(s_busy), 32'd0);
      check("lit_div_cnt",  s_cnt,       32'd33);

      // Hazard and a repeated div_start while BUSY.
      start_div();
      idle(3);
      step(0, 1, 0, 1, 1, 5'd7, 0, 5'd0, 1, 5'd7);
      check("lit_busy_lu_stall", {26'd0, s_stall}, 32'h0f);
      check("lit_busy_no_go",    32'(s_go),        32'd0);
      idle(N + 2);

      // Flush with counter = 17 (15 cycles after div_go).
      start_div();
      idle(14);
      step(0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      check("lit_flush_stall", {26'd0, s_stall}, 32'h0f);
      idle(1);
      check("lit_flush_busy",  32'(s_busy),      32'd0);
      check("lit_flush_stall2", {26'd0, s_stall}, 32'd0);
      check("lit_flush_done",  32'(s_done),      32'd0);
      idle(N + 2);

      // Asynchronous reset between edges during BUSY.
      start_div();
      idle(5);
      #1 rst = 1'b1;
      #1;
      check("lit_arst_busy",  32'(busy),        32'd0);
      check("lit_arst_stall", {26'd0, stall},   32'd0);
      check("lit_arst_cnt",   stall_cnt,        32'd0);
      phase = -1;
      m_cnt = '0;
      step(1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0);
      start_div();
      check("lit_arst_go", 32'(s_go), 32'd1);
      idle(N + 3);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         logic       r;
         logic       ds;
         logic       fl;
         logic [4:0] wa;
         logic [4:0] ra1;
         logic [4:0] ra2;
         r   = ($urandom_range(0, 299) == 0);
         ds  = ($urandom_range(0, 7) == 0);
         fl  = ($urandom_range(0, 39) == 0);
         wa  = 5'($urandom_range(0, 3));
         ra1 = 5'($urandom_range(0, 3));
         ra2 = 5'($urandom_range(0, 3));
         step(r, ds, fl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), wa,
              1'($urandom_range(0, 1)), ra1, 1'($urandom_range(0, 1)), ra2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stall_sched.md
STALL_SCHED -- requirements
Module: stall_sched

Interface
REQ-001 Parameter DIV_CYCLES, default 32, number of BUSY cycles per divide; legal range 2..63.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 id_re1  input  1  ID stage reads source operand 1.
REQ-005 id_raddr1  input  5  ID stage source register 1 address.
REQ-006 id_re2  input  1  ID stage reads source operand 2.
REQ-007 id_raddr2  input  5  ID stage source register 2 address.
REQ-008 ex_wreg  input  1  EX stage instruction writes a register.
REQ-009 ex_waddr  input  5  EX stage destination register.
REQ-010 ex_is_load  input  1  EX stage instruction is a load; its data is not on the forwarding path until MEM.
REQ-011 div_start  input  1  EX stage holds a valid divide instruction.
REQ-012 flush  input  1  pipeline flush; aborts an in-flight divide.
REQ-013 stall  output  6  per-stage hold: bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB.
REQ-014 div_go  output  1  one-cycle start pulse to the external iterative divider.
REQ-015 div_done  output  1  one-cycle pulse: divider result valid, write HI/LO this cycle.
REQ-016 busy  output  1  high while the FSM is not in IDLE.
REQ-017 stall_cnt  output  32  count of cycles in which stall != 0.

Function
REQ-018 Load-use hazard (lu) SHALL be asserted combinationally when ex_is_load & ex_wreg & ex_waddr != 0 & ((id_re1 & id_raddr1 == ex_waddr) | (id_re2 & id_raddr2 == ex_waddr)).
REQ-019 When lu is set, stall SHALL include 6'b000111, inserting exactly one bubble into EX; the next cycle lu re-evaluates against new EX contents.
REQ-020 Register $0 SHALL never cause a hazard.
REQ-021 FSM states SHALL be IDLE, BUSY and DONE.
REQ-022 IDLE with div_start=1 and flush=0: div_go=1 this cycle, counter loads DIV_CYCLES-1, next state BUSY, stall includes 6'b001111 this cycle.
REQ-023 In BUSY, stall SHALL include 6'b001111; counter decrements by 1 per cycle; counter == 0 -> DONE.
REQ-024 In DONE: div_done=1, the FSM contributes no stall bits, next state IDLE.
REQ-025 div_start SHALL be ignored in BUSY and DONE; a new divide is accepted only from IDLE, so back-to-back divides are separated by at least one IDLE cycle.
REQ-026 flush=1 in any state SHALL force next state IDLE, clear the counter and suppress div_go and div_done that cycle.
REQ-027 stall SHALL be the bitwise OR of the lu term and the FSM term.
REQ-028 Divide latency SHALL be: div_go in cycle T, div_done in cycle T+DIV_CYCLES+1, with EX held for cycles T..T+DIV_CYCLES.
REQ-029 stall_cnt SHALL increment by 1 on every edge where stall != 0 and rst=0, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-030 busy SHALL equal (state != IDLE).

Reset
REQ-031 rst=1 SHALL immediately, without waiting for a clock edge, set state to IDLE, counter to 0 and stall_cnt to 0.
REQ-032 While rst=1, stall, div_go, div_done and busy SHALL be 0 regardless of inputs.
REQ-033 If rst asserts mid-divide, no div_done is produced; after release the FSM is in IDLE and accepts div_start on the first cycle.

Verification
REQ-034 ex_is_load=1, ex_wreg=1, ex_waddr=5, id_re1=1, id_raddr1=5 for one cycle -> stall=6'b000111 for that cycle, stall_cnt=1.
REQ-035 The same as REQ-034 but ex_waddr=0 and id_raddr1=0 -> stall=0, stall_cnt unchanged.
REQ-036 DIV_CYCLES=32, div_start pulse at cycle 10 -> div_go=1 at 10, stall=6'b001111 for cycles 10..42, div_done=1 at 43, busy=0 at 44, stall_cnt=33.
REQ-037 A divide in BUSY with a concurrent load-use hazard -> stall=6'b001111; div_start re-asserted in BUSY -> no second div_go.
REQ-038 flush=1 at counter=17 -> IDLE next cycle, no div_done, stall=0, busy=0.
REQ-039 rst asserted asynchronously between edges during BUSY -> busy and stall go to 0 before the next edge; after release, div_start -> div_go the same cycle.
